add8_simd_pipe: RTL and testbench
=================================

// Module: add8_simd_pipe
// PURPOSE
//   Pipelined, multi-precision packed-integer add with true saturation, for the integer datapath.
//   Per lane it adds a narrow element (src0, N bits) to a wide element ({src2,src1}, 2N bits).
//   The result is 2N bits, clamped to its range, and split into low half (dst0) and high half (dst1).
//   N is chosen per transaction by mode. valid/ready in and out; saturation is flagged and counted.
// PARAMETERS
//   DATA_W     128  width of every src/dst bus; must be a multiple of 16
//   SAT_CNT_W  16   width of saturating lane-saturation event counter
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst_n      in   1        reset, synchronous, active-low
//   in_valid   in   1        input transaction valid
//   in_ready   out  1        block can accept this cycle
//   mode       in   2        0: N=4 (DATA_W/4 lanes); 1: N=8; 2: N=16; 3: illegal
//   sign_s0    in   1        1: src0 lane is two's complement; 0: unsigned
//   sign_s2    in   1        1: {src2,src1} lane is two's complement; 0: unsigned
//   src0       in   DATA_W   narrow addend, N bits per lane
//   src1       in   DATA_W   low half of wide addend, N bits per lane
//   src2       in   DATA_W   high half of wide addend, N bits per lane
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts this cycle
//   dst0       out  DATA_W   result bits [N-1:0] per lane
//   dst1       out  DATA_W   result bits [2N-1:N] per lane
//   sat_flag   out  1        any lane of this result saturated (qualified by out_valid)
//   mode_err   out  1        result came from mode==3 (qualified by out_valid)
//   sat_cnt    out  SAT_CNT_W  count of saturated result transactions; saturates at all-ones
//   sat_clr    in   1        clears sat_cnt next cycle; a count on the same cycle is dropped
// BEHAVIOUR
// - Reset (rst_n==0 at an edge): stage valids=0, out_valid=0, dst0/dst1=0, sat_flag=0, mode_err=0, sat_cnt=0.
//   A transaction in flight is discarded. in_ready is 1 in the cycle after reset.
// - Pipeline: S1 registers mode, signs and srcs. S2 registers the computed dst0/dst1/flags.
//   Transfer happens when in_valid && in_ready. Latency: accepted at edge T, out_valid=1 after edge T+1.
// - Flow: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational).
//   No bubbles: full throughput of 1 transaction/cycle while out_ready=1.
//   out_valid/dst stay stable while out_valid && !out_ready. Order is preserved. Nothing is dropped or duplicated.
// - Lane math, lane k, L = DATA_W/N lanes:
//   a = src0[kN+:N], extended by sign_s0. b = {src2[kN+:N], src1[kN+:N]}, extended by sign_s2.
//   Exact sum s is formed in 2N+2 bits, signed.
//   Result signed if sign_s0 || sign_s2: clamp s to [-2^(2N-1), 2^(2N-1)-1].
//   Both unsigned: clamp s to [0, 2^(2N)-1]. sat_k = clamp applied.
//   dst0[kN+:N] = r[N-1:0]; dst1[kN+:N] = r[2N-1:N].
// - sat_flag = OR of sat_k over all lanes.
// - mode==3: dst0=dst1=0, sat_flag=0, mode_err=1. It still flows through the pipe with normal handshake.
// - sat_cnt increments by 1 on each output handshake (out_valid && out_ready) with sat_flag=1, unless at max.
//   sat_clr has priority over the increment.
// - mode/sign are per transaction. Back-to-back transactions with different modes are legal.
// TESTING
// - mode0 signed/signed: all lanes src0=0x7, src1=0xF, src2=0x7 (7+127=134).
//   -> dst1=0x777..7, dst0=0xFFF..F, sat_flag=1.
// - mode0 signed: src0=0x8, src2=0x8, src1=0x0 (-8 + -128) -> result 0x80 per lane (dst1=0x8, dst0=0x0), sat_flag=1.
//   mode0 unsigned: src0=0xF, b=0xFF -> 0xFF, sat_flag=1.
//   mode0 unsigned: src0=0x1, b=0x10 -> 0x11, sat_flag=0.
// - mode1 mixed: sign_s0=1 src0=0xFF (-1), sign_s2=0 b=0x0000 -> r=0xFFFF, sat_flag=0.
//   mode2 signed: src0=0x0001, b=0x7FFFFFFF -> 0x7FFFFFFF, sat_flag=1.
// - Backpressure: 4 back-to-back inputs while out_ready=0 for 6 cycles.
//   -> in_ready drops after 2 accepted, out data held stable; on release, 4 outputs in order, 1 per cycle.
// - mode=3 between two mode0 transactions -> middle output zero with mode_err=1, neighbours correct.
//   sat_cnt counts only saturated handshakes, then clears on sat_clr.
// - Assert rst_n=0 for 1 cycle with 2 transactions in flight.
//   -> out_valid=0 and sat_cnt=0 next cycle, in_ready=1, no stale output afterwards.

Source files
------------

// File: rtl/add8_simd_pipe.sv
// add8_simd_pipe: two-stage packed-integer add with per-lane saturation.
// Each lane adds an N-bit element (src0) to a 2N-bit element ({src2,src1}).
// The 2N-bit clamped result is returned split into halves: dst0 = low, dst1 = high.
// The lane width N is 4, 8 or 16 and is selected per transaction by mode.
module add8_simd_pipe #(
   parameter int DATA_W    = 128,
   parameter int SAT_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic                 sign_s0,
   input  logic                 sign_s2,
   input  logic [DATA_W-1:0]    src0,
   input  logic [DATA_W-1:0]    src1,
   input  logic [DATA_W-1:0]    src2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    dst0,
   output logic [DATA_W-1:0]    dst1,
   output logic                 sat_flag,
   output logic                 mode_err,
   output logic [SAT_CNT_W-1:0] sat_cnt,
   input  logic                 sat_clr
);

   // Extend the low n bits of v to 34 bits, either sign-extended or zero-extended.
   // Every lane width funnels through this one 34-bit form, which holds any exact sum.
   function automatic logic signed [33:0] ext_lane(input logic [31:0] v,
                                                   input int          n,
                                                   input logic        sgn);
      logic signed [33:0] x;
      x = (sgn && v[n-1]) ? '1 : '0;
      for (int i = 0; i < 32; i++) begin
         if (i < n) x[i] = v[i];
      end
      return x;
   endfunction

   // Clamp an exact sum to the 2n-bit result range.
   // Return value: bit 32 is the saturation flag; bits [2n-1:0] are the result.
   function automatic logic [32:0] sat_clamp(input logic signed [33:0] s,
                                             input logic               is_signed,
                                             input int                 n);
      logic signed [33:0] hi;
      logic signed [33:0] lo;
      logic [32:0]        res;
      if (is_signed) begin
         hi = (34'sd1 <<< (2*n - 1)) - 34'sd1;
         lo = -(34'sd1 <<< (2*n - 1));
      end else begin
         hi = (34'sd1 <<< (2*n)) - 34'sd1;
         lo = '0;
      end
      if (s > hi)      res = {1'b1, hi[31:0]};
      else if (s < lo) res = {1'b1, lo[31:0]};
      else             res = {1'b0, s[31:0]};
      return res;
   endfunction

   logic                 adv1;
   logic                 adv2;
   logic                 vld_p1;
   logic [1:0]           mode_p1;
   logic                 sgn0_p1;
   logic                 sgn2_p1;
   logic [DATA_W-1:0]    src0_p1;
   logic [DATA_W-1:0]    src1_p1;
   logic [DATA_W-1:0]    src2_p1;
   logic [2:0][DATA_W-1:0] d0_m;
   logic [2:0][DATA_W-1:0] d1_m;
   logic [2:0]           sat_m;
   logic [DATA_W-1:0]    res_d0;
   logic [DATA_W-1:0]    res_d1;
   logic                 res_sat;
   logic                 res_merr;
   logic                 vld_p2;
   logic [DATA_W-1:0]    dst0_p2;
   logic [DATA_W-1:0]    dst1_p2;
   logic                 sat_p2;
   logic                 merr_p2;
   logic [SAT_CNT_W-1:0] sat_cnt_q;

   // Stage 2 advances when it is empty or its output is taken.
   // Stage 1 advances when it is empty or stage 2 advances.
   // This gives full throughput with no bubbles.
   assign adv2     = !vld_p2 || out_ready;
   assign adv1     = !vld_p1 || adv2;
   assign in_ready = adv1;

   // ---- stage 1: capture the transaction ----
   // Stage 1 valid: the only stage-1 state that needs a reset.
   always_ff @(posedge clk) begin
      if (!rst_n)    vld_p1 <= 1'b0;
      else if (adv1) vld_p1 <= in_valid;
   end

   // Stage 1 operands: loaded on every accepted input.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         mode_p1 <= mode;
         sgn0_p1 <= sign_s0;
         sgn2_p1 <= sign_s2;
         src0_p1 <= src0;
         src1_p1 <= src1;
         src2_p1 <= src2;
      end
   end

   // The results for all three lane widths are computed in parallel.
   // The mode held in stage 1 then selects one of them.
   for (genvar m = 0; m < 3; m++) begin : g_mode
      localparam int N = 4 << m;
      localparam int L = DATA_W / N;
      logic [L-1:0] lane_sat;
      for (genvar k = 0; k < L; k++) begin : g_lane
         logic signed [33:0] a_x;
         logic signed [33:0] b_x;
         logic signed [33:0] s_x;
         logic [32:0]        cl;
         assign a_x = ext_lane(32'(src0_p1[k*N +: N]), N, sgn0_p1);
         assign b_x = ext_lane(32'({src2_p1[k*N +: N], src1_p1[k*N +: N]}), 2*N, sgn2_p1);
         assign s_x = a_x + b_x;
         assign cl  = sat_clamp(s_x, sgn0_p1 | sgn2_p1, N);
         assign d0_m[m][k*N +: N] = cl[N-1:0];
         assign d1_m[m][k*N +: N] = cl[2*N-1:N];
         assign lane_sat[k]       = cl[32];
      end
      assign sat_m[m] = |lane_sat;
   end

   // Select the active lane width.
   // Mode 3 yields a zero result with only the error flag set.
   always_comb begin
      res_d0   = '0;
      res_d1   = '0;
      res_sat  = 1'b0;
      res_merr = 1'b0;
      case (mode_p1)
         2'd0, 2'd1, 2'd2: begin
            res_d0  = d0_m[mode_p1];
            res_d1  = d1_m[mode_p1];
            res_sat = sat_m[mode_p1];
         end
         default: res_merr = 1'b1;
      endcase
   end

   // ---- stage 2: registered result ----
   // Stage 2 result registers.
   // They hold their value while the output is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         dst0_p2 <= '0;
         dst1_p2 <= '0;
         sat_p2  <= 1'b0;
         merr_p2 <= 1'b0;
      end else if (adv2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            dst0_p2 <= res_d0;
            dst1_p2 <= res_d1;
            sat_p2  <= res_sat;
            merr_p2 <= res_merr;
         end
      end
   end

   // Count saturated output handshakes, stopping at all-ones.
   // A clear takes priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sat_cnt_q <= '0;
      else if (sat_clr)
         sat_cnt_q <= '0;
      else if (vld_p2 && out_ready && sat_p2 && (sat_cnt_q != {SAT_CNT_W{1'b1}}))
         sat_cnt_q <= sat_cnt_q + 1'b1;
   end

   assign out_valid = vld_p2;
   assign dst0      = dst0_p2;
   assign dst1      = dst1_p2;
   assign sat_flag  = sat_p2;
   assign mode_err  = merr_p2;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_add8_simd_pipe.sv
// tb_add8_simd_pipe: directed and randomized checks of add8_simd_pipe.
// Expected results come from an integer model and a queue-based scoreboard.
module tb_add8_simd_pipe;

   localparam int DATA_W    = 128;
   localparam int SAT_CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        mode = 2'd0;
   logic              sign_s0 = 1'b0;
   logic              sign_s2 = 1'b0;
   logic [DATA_W-1:0] src0 = '0;
   logic [DATA_W-1:0] src1 = '0;
   logic [DATA_W-1:0] src2 = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] dst0;
   logic [DATA_W-1:0] dst1;
   logic              sat_flag;
   logic              mode_err;
   logic [SAT_CNT_W-1:0] sat_cnt;
   logic              sat_clr = 1'b0;

   add8_simd_pipe #(.DATA_W(DATA_W), .SAT_CNT_W(SAT_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sign_s0(sign_s0), .sign_s2(sign_s2),
      .src0(src0), .src1(src1), .src2(src2),
      .out_valid(out_valid), .out_ready(out_ready), .dst0(dst0), .dst1(dst1),
      .sat_flag(sat_flag), .mode_err(mode_err), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      logic              sat;
      logic              merr;
   } exp_t;

   exp_t              sb[$];
   int                n_vec = 0;
   int                n_err = 0;
   int                n_out = 0;
   logic [SAT_CNT_W-1:0] cnt_model = '0;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_d0, prev_d1;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference: exact integer sum per lane, clamped to the 2N-bit range.
   function automatic exp_t model(input logic [1:0] md, input logic s0, input logic s2,
                                  input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] x1,
                                  input logic [DATA_W-1:0] x2);
      exp_t e;
      int n;
      longint msk, a, b, s, hi, lo;
      logic [DATA_W-1:0] t0, t1, t2;
      e.d0 = '0; e.d1 = '0; e.sat = 1'b0; e.merr = 1'b0;
      if (md == 2'd3) begin
         e.merr = 1'b1;
         return e;
      end
      n   = 4 << md;
      msk = (64'sd1 <<< n) - 1;
      for (int k = 0; k < DATA_W / n; k++) begin
         t0 = x0 >> (k * n);
         t1 = x1 >> (k * n);
         t2 = x2 >> (k * n);
         a = longint'(t0[31:0]) & msk;
         if (s0 && a >= (64'sd1 <<< (n - 1))) a -= (64'sd1 <<< n);
         b = ((longint'(t2[31:0]) & msk) <<< n) | (longint'(t1[31:0]) & msk);
         if (s2 && b >= (64'sd1 <<< (2*n - 1))) b -= (64'sd1 <<< (2*n));
         s = a + b;
         if (s0 || s2) begin
            hi = (64'sd1 <<< (2*n - 1)) - 1;
            lo = -(64'sd1 <<< (2*n - 1));
         end else begin
            hi = (64'sd1 <<< (2*n)) - 1;
            lo = 0;
         end
         if (s > hi) begin s = hi; e.sat = 1'b1; end
         else if (s < lo) begin s = lo; e.sat = 1'b1; end
         e.d0 |= DATA_W'(s & msk) << (k * n);
         e.d1 |= DATA_W'((s >>> n) & msk) << (k * n);
      end
      return e;
   endfunction

   // One clock cycle: apply ready/clear, score handshakes, advance, check counter.
   task automatic tick(input logic ordy, input logic clr, output bit acc);
      exp_t e;
      bit   ohs;
      out_ready = ordy;
      sat_clr   = clr;
      #1;
      if (prev_stall) begin
         chk("hold_dst0", dst0, prev_d0);
         chk("hold_dst1", dst1, prev_d1);
      end
      acc = (in_valid && in_ready);
      ohs = (out_valid && out_ready);
      if (ohs) begin
         n_out++;
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
            e.sat = 1'b0;
         end else begin
            e = sb.pop_front();
            chk("dst0", dst0, e.d0);
            chk("dst1", dst1, e.d1);
            chk("sat_flag", sat_flag, e.sat);
            chk("mode_err", mode_err, e.merr);
         end
      end
      if (clr) cnt_model = '0;
      else if (ohs && e.sat && cnt_model != '1) cnt_model = cnt_model + 1'b1;
      if (acc) sb.push_back(model(mode, sign_s0, sign_s2, src0, src1, src2));
      prev_stall = (out_valid && !out_ready);
      prev_d0 = dst0;
      prev_d1 = dst1;
      @(posedge clk);
      if (!rst_n) begin
         sb.delete();
         cnt_model  = '0;
         prev_stall = 1'b0;
      end
      @(negedge clk);
      chk("sat_cnt", sat_cnt, cnt_model);
   endtask

   function automatic logic [DATA_W-1:0] rnd_bus();
      logic [DATA_W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = '1;
         1: v = '0;
         2: v = {16{8'h7F}};
         3: v = {16{8'h80}};
         default: v = {$urandom, $urandom, $urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic load_rand(input bit allow3);
      mode    = allow3 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      sign_s0 = 1'($urandom);
      sign_s2 = 1'($urandom);
      src0    = rnd_bus();
      src1    = rnd_bus();
      src2    = rnd_bus();
   endtask

   task automatic send(input logic [1:0] md, input logic s0, input logic s2,
                       input logic [DATA_W-1:0] x0, input logic [DATA_W-1:0] x1,
                       input logic [DATA_W-1:0] x2);
      bit acc;
      int c;
      in_valid = 1'b1; mode = md; sign_s0 = s0; sign_s2 = s2;
      src0 = x0; src1 = x1; src2 = x2;
      c = 0;
      do begin
         tick(1'b1, 1'b0, acc);
         c++;
      end while (!acc && c < 50);
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit acc;
      int c;
      in_valid = 1'b0;
      c = 0;
      while ((sb.size() != 0 || out_valid) && c < 100) begin
         tick(1'b1, 1'b0, acc);
         c++;
      end
      chk("drain_empty", DATA_W'(sb.size()), 0);
   endtask

   task automatic expect_out(input string tag, input logic [DATA_W-1:0] e0,
                             input logic [DATA_W-1:0] e1, input logic es);
      bit acc;
      int c;
      in_valid = 1'b0;
      c = 0;
      while (!out_valid && c < 10) begin
         tick(1'b0, 1'b0, acc);
         c++;
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_dst0"}, dst0, e0);
      chk({tag, "_dst1"}, dst1, e1);
      chk({tag, "_sat"}, sat_flag, es);
      chk({tag, "_merr"}, mode_err, 0);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n_acc, out0, idx, cyc, sent;

      // Reset state
      rst_n = 1'b0;
      tick(1'b0, 1'b0, acc);
      tick(1'b0, 1'b0, acc);
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dst0", dst0, 0);
      chk("rst_dst1", dst1, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_mode_err", mode_err, 0);
      chk("rst_in_ready", in_ready, 1);

      // Directed lane-math vectors
      send(2'd0, 1, 1, {32{4'h7}}, {32{4'hF}}, {32{4'h7}});
      expect_out("m0_pos_sat", {32{4'hF}}, {32{4'h7}}, 1);
      send(2'd0, 1, 1, {32{4'h8}}, {32{4'h0}}, {32{4'h8}});
      expect_out("m0_neg_sat", {32{4'h0}}, {32{4'h8}}, 1);
      send(2'd0, 0, 0, {32{4'hF}}, {32{4'hF}}, {32{4'hF}});
      expect_out("m0_u_sat", {32{4'hF}}, {32{4'hF}}, 1);
      send(2'd0, 0, 0, {32{4'h1}}, {32{4'h0}}, {32{4'h1}});
      expect_out("m0_u_nosat", {32{4'h1}}, {32{4'h1}}, 0);
      send(2'd1, 1, 0, {16{8'hFF}}, {16{8'h00}}, {16{8'h00}});
      expect_out("m1_mixed", {16{8'hFF}}, {16{8'hFF}}, 0);
      send(2'd2, 1, 1, {8{16'h0001}}, {8{16'hFFFF}}, {8{16'h7FFF}});
      expect_out("m2_pos_sat", {8{16'hFFFF}}, {8{16'h7FFF}}, 1);

      // Backpressure: 4 back-to-back inputs while output is stalled
      in_valid = 1'b1;
      load_rand(0);
      n_acc = 0; idx = 0;
      for (int c = 0; c < 6; c++) begin
         tick(1'b0, 1'b0, acc);
         if (acc) begin n_acc++; idx++; load_rand(0); end
      end
      chk("bp_accepted", DATA_W'(n_acc), 2);
      chk("bp_in_ready", in_ready, 0);
      out0 = n_out;
      for (int c = 0; c < 4; c++) begin
         tick(1'b1, 1'b0, acc);
         if (acc) begin
            idx++;
            if (idx < 4) load_rand(0); else in_valid = 1'b0;
         end
      end
      chk("bp_out_rate", DATA_W'(n_out - out0), 4);
      chk("bp_empty", DATA_W'(sb.size()), 0);

      // Reset with two transactions in flight
      in_valid = 1'b1;
      load_rand(0);
      tick(1'b0, 1'b0, acc);
      load_rand(0);
      tick(1'b0, 1'b0, acc);
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick(1'b0, 1'b0, acc);
      rst_n = 1'b1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sat_cnt", sat_cnt, 0);
      chk("midrst_in_ready", in_ready, 1);
      for (int c = 0; c < 4; c++) begin
         tick(1'b1, 1'b0, acc);
         chk("midrst_no_stale", out_valid, 0);
      end

      // Mode 3 between two saturating mode-0 transactions; counter and clear
      tick(1'b1, 1'b1, acc);
      send(2'd0, 1, 1, {32{4'h7}}, {32{4'hF}}, {32{4'h7}});
      send(2'd3, 1, 0, {$urandom, $urandom, $urandom, $urandom}, '1, '1);
      send(2'd0, 1, 1, {32{4'h8}}, {32{4'h0}}, {32{4'h8}});
      drain();
      chk("cnt_two", sat_cnt, 2);
      tick(1'b1, 1'b1, acc);
      chk("cnt_clr", sat_cnt, 0);

      // Randomized traffic with random backpressure and occasional clears
      sent = 0; cyc = 0;
      while (sent < 400 && cyc < 5000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            load_rand(1);
         end
         tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), acc);
         if (acc) begin
            sent++;
            if ($urandom_range(0, 1) == 1) load_rand(1); else in_valid = 1'b0;
         end
         cyc++;
      end
      chk("rand_sent", DATA_W'(sent), 400);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
